// File: rtl/chip8_mem_loader.sv
// rtl/chip8_mem_loader.sv - CHIP-8 boot loader: hex font, then program ROM, into main RAM
//
// Purpose: after reset (or a start pulse once loaded) writes the 80-byte hex
// font to RAM at FONT_BASE, then copies PROG_LEN bytes from the asynchronous
// program ROM to RAM at PROG_START, one byte per cycle with no gaps. The CPU
// is held in reset until the copy has finished.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   start        one-cycle pulse, reloads RAM when already done
//   rom_address  program ROM read address (combinational from the byte counter)
//   rom_data     program ROM data, valid in the same cycle as rom_address
//   ram_address  registered RAM write address
//   ram_data     registered RAM write data
//   ram_we       registered RAM write strobe, one byte per high cycle
//   done         RAM fully loaded
//   cpu_hold     CPU reset hold, always ~done
module chip8_mem_loader #(
  parameter logic [11:0] PROG_START = 12'h200,
  parameter int          PROG_LEN   = 256,
  parameter logic [11:0] FONT_BASE  = 12'h000,
  parameter bit          LOAD_FONT  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [11:0] rom_address,
  input  logic [7:0]  rom_data,
  output logic [11:0] ram_address,
  output logic [7:0]  ram_data,
  output logic        ram_we,
  output logic        done,
  output logic        cpu_hold
);

  typedef enum logic [1:0] {ST_FONT, ST_PROG, ST_FIN, ST_DONE} state_t;

  localparam state_t      LOAD_STATE = LOAD_FONT ? ST_FONT : ST_PROG;
  localparam logic [11:0] FONT_LAST  = 12'd79;
  localparam logic [11:0] PROG_LAST  = 12'(PROG_LEN - 1);

  // Glyphs 0..F, five rows each; font byte 0 sits in the top byte.
  localparam logic [639:0] FONT_BITS = {
    40'hF0909090F0, 40'h2060202070, 40'hF010F080F0, 40'hF010F010F0,
    40'h9090F01010, 40'hF080F010F0, 40'hF080F090F0, 40'hF010204040,
    40'hF090F090F0, 40'hF090F010F0, 40'hF090F09090, 40'hE090E090E0,
    40'hF0808080F0, 40'hE0909090E0, 40'hF080F080F0, 40'hF080F08080
  };

  state_t      state;
  logic [11:0] count;
  logic [9:0]  font_pos;
  logic [7:0]  font_byte;

  assign rom_address = PROG_START + count;
  assign cpu_hold    = ~done;

  // Bit offset of font[count] counted from the LSB of FONT_BITS; outside the
  // font range the counter is indexing program bytes, so return zero.
  always_comb begin
    font_pos  = {3'b000, 7'd79 - count[6:0]} << 3;
    font_byte = 8'h00;
    if (count <= FONT_LAST) begin
      font_byte = FONT_BITS[font_pos +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= LOAD_STATE;
      count       <= 12'd0;
      ram_we      <= 1'b0;
      ram_address <= 12'd0;
      ram_data    <= 8'd0;
      done        <= 1'b0;
    end else begin
      case (state)
        ST_FONT: begin
          ram_address <= FONT_BASE + count;
          ram_data    <= font_byte;
          ram_we      <= 1'b1;
          if (count == FONT_LAST) begin
            count <= 12'd0;
            state <= ST_PROG;
          end else begin
            count <= count + 12'd1;
          end
        end
        ST_PROG: begin
          ram_address <= rom_address;
          ram_data    <= rom_data;
          ram_we      <= 1'b1;
          if (count == PROG_LAST) begin
            state <= ST_FIN;
          end else begin
            count <= count + 12'd1;
          end
        end
        ST_FIN: begin
          ram_we <= 1'b0;
          done   <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          // Address and data hold their last values while idle.
          ram_we <= 1'b0;
          if (start) begin
            done  <= 1'b0;
            count <= 12'd0;
            state <= LOAD_STATE;
          end
        end
        default: begin
          ram_we <= 1'b0;
          state  <= LOAD_STATE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_mem_loader.sv
// tb/tb_chip8_mem_loader.sv - self-checking bench for chip8_mem_loader
module tb_chip8_mem_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        reset_n, start;
  logic [11:0] rom_address, ram_address;
  logic [7:0]  rom_data, ram_data;
  logic        ram_we, done, cpu_hold;

  // LOAD_FONT=0, PROG_LEN=4 instance
  logic        s_reset_n, s_start;
  logic [11:0] s_rom_address, s_ram_address;
  logic [7:0]  s_rom_data, s_ram_data;
  logic        s_ram_we, s_done, s_cpu_hold;

  logic [7:0]  rom_mem [4096];
  assign rom_data   = rom_mem[rom_address];
  assign s_rom_data = s_rom_address[7:0] ^ 8'h5A;

  chip8_mem_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .rom_address(rom_address), .rom_data(rom_data),
    .ram_address(ram_address), .ram_data(ram_data), .ram_we(ram_we),
    .done(done), .cpu_hold(cpu_hold)
  );

  chip8_mem_loader #(.PROG_LEN(4), .LOAD_FONT(1'b0)) dut_small (
    .clk(clk), .reset_n(s_reset_n), .start(s_start),
    .rom_address(s_rom_address), .rom_data(s_rom_data),
    .ram_address(s_ram_address), .ram_data(s_ram_data), .ram_we(s_ram_we),
    .done(s_done), .cpu_hold(s_cpu_hold)
  );

  typedef struct packed {
    logic [31:0] e;
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct {
    int          cyc;
    logic [11:0] a;
    logic [7:0]  d;
    logic        we;
    logic        dn;
  } vec_t;

  int unsigned edge_n = 0;
  wr_t cap[$];
  wr_t cap_s[$];
  wr_t expq[$];
  int  passed = 0;
  int  total  = 0;

  logic [39:0] glyphs [16] = '{
    40'hF0909090F0, 40'h2060202070, 40'hF010F080F0, 40'hF010F010F0,
    40'h9090F01010, 40'hF080F010F0, 40'hF080F090F0, 40'hF010204040,
    40'hF090F090F0, 40'hF090F010F0, 40'hF090F09090, 40'hE090E090E0,
    40'hF0808080F0, 40'hE0909090E0, 40'hF080F080F0, 40'hF080F08080
  };

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (ram_we)   cap.push_back(wr_t'({edge_n, ram_address, ram_data}));
    if (s_ram_we) cap_s.push_back(wr_t'({edge_n, s_ram_address, s_ram_data}));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  function automatic logic [7:0] font_ref(input int i);
    logic [39:0] g;
    g = glyphs[i / 5];
    return g[39 - 8 * (i % 5) -: 8];
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h required %0h", nm, got, want);
  endtask

  // Expected writes of a default load (80 font bytes then 256 program bytes),
  // the first of them visible at edge count 'base'; only the first nwr kept.
  task automatic add_load(input int unsigned base, input int nwr);
    logic [11:0] pa;
    for (int i = 0; i < 336 && i < nwr; i++) begin
      if (i < 80) begin
        expq.push_back(wr_t'({32'(base + 32'(i)), 12'(i), font_ref(i)}));
      end else begin
        pa = 12'h200 + 12'(i - 80);
        expq.push_back(wr_t'({32'(base + 32'(i)), pa, rom_mem[pa]}));
      end
    end
  endtask

  task automatic check_seq(input string nm);
    int nbad = 0;
    for (int i = 0; i < cap.size() && i < expq.size(); i++)
      if (cap[i] !== expq[i]) nbad++;
    check({nm, "_count"}, 64'(cap.size()), 64'(expq.size()));
    check({nm, "_mismatches"}, 64'(nbad), 64'd0);
  endtask

  task automatic wait_done(input string nm, input int unsigned want_edge);
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(nm, 64'(edge_n), 64'(want_edge));
    check({nm, "_hold"}, 64'(cpu_hold), 64'd0);
  endtask

  // Start is sampled at the next edge; writes then begin one edge later.
  task automatic pulse_start(input string nm, output int unsigned e0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check(nm, 64'({done, cpu_hold}), 64'(2'b01));
    e0 = edge_n + 1;
  endtask

  vec_t vt [8];
  int unsigned e_base, e_base2;
  logic [7:0] sd [4];

  initial begin
    vt[0] = '{1,   12'h000, 8'hF0, 1'b1, 1'b0};
    vt[1] = '{2,   12'h001, 8'h90, 1'b1, 1'b0};
    vt[2] = '{6,   12'h005, 8'h20, 1'b1, 1'b0};
    vt[3] = '{80,  12'h04F, 8'h80, 1'b1, 1'b0};
    vt[4] = '{81,  12'h200, 8'h5A, 1'b1, 1'b0};
    vt[5] = '{82,  12'h201, 8'h5B, 1'b1, 1'b0};
    vt[6] = '{336, 12'h2FF, 8'hA5, 1'b1, 1'b0};
    vt[7] = '{337, 12'h2FF, 8'hA5, 1'b0, 1'b1};
    sd[0] = 8'h5A; sd[1] = 8'h5B; sd[2] = 8'h58; sd[3] = 8'h59;

    for (int a = 0; a < 4096; a++) rom_mem[a] = 8'(a) ^ 8'h5A;
    reset_n = 1'b0; start = 1'b0; s_reset_n = 1'b0; s_start = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_port", 64'({ram_we, ram_address, ram_data}), 64'd0);
    check("rst_done", 64'({done, cpu_hold}), 64'(2'b01));
    check("rst_rom_address", 64'(rom_address), 64'h200);

    // run 1: release reset, table of port values at chosen cycles
    cap.delete();
    reset_n = 1'b1;
    @(negedge clk);
    e_base = edge_n;
    foreach (vt[k]) begin
      while (int'(edge_n - e_base) + 1 < vt[k].cyc) @(negedge clk);
      check($sformatf("vec_cycle%0d", vt[k].cyc),
            64'({ram_we, done, cpu_hold, ram_address, ram_data}),
            64'({vt[k].we, vt[k].dn, ~vt[k].dn, vt[k].a, vt[k].d}));
    end
    repeat (4) @(negedge clk);
    expq.delete();
    add_load(e_base, 336);
    check_seq("load1");

    // run 2: reload from DONE with fresh ROM, start pulse at cycle 100 ignored
    for (int a = 0; a < 4096; a++) rom_mem[a] = 8'($urandom);
    cap.delete();
    pulse_start("start2_done_clr", e_base);
    while (int'(edge_n - e_base) + 1 < 100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("done2_edge", e_base + 336);
    repeat (4) @(negedge clk);
    expq.delete();
    add_load(e_base, 336);
    check_seq("load2");

    // run 3: reset for two cycles at cycle 150 aborts and restarts the load
    cap.delete();
    pulse_start("start3_done_clr", e_base);
    while (int'(edge_n - e_base) + 1 < 150) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_rst1", 64'({ram_we, done, cpu_hold}), 64'(3'b001));
    @(negedge clk);
    check("abort_rst2", 64'({ram_we, done, cpu_hold}), 64'(3'b001));
    reset_n = 1'b1;
    @(negedge clk);
    e_base2 = edge_n;
    check("abort_first_write", 64'({ram_we, ram_address, ram_data}), 64'({1'b1, 12'h000, 8'hF0}));
    wait_done("done3_edge", e_base2 + 336);
    repeat (4) @(negedge clk);
    expq.delete();
    add_load(e_base, 150);
    add_load(e_base2, 336);
    check_seq("load3");

    // random ROM contents with random start noise throughout the load
    for (int it = 0; it < 3; it++) begin
      for (int a = 0; a < 4096; a++) rom_mem[a] = 8'($urandom);
      cap.delete();
      pulse_start($sformatf("rnd%0d_done_clr", it), e_base);
      for (int n = 0; n < 2000 && !done; n++) begin
        start = ($urandom_range(0, 15) == 0);
        @(negedge clk);
      end
      start = 1'b0;
      check($sformatf("rnd%0d_done_edge", it), 64'(edge_n), 64'(e_base + 336));
      repeat (4) @(negedge clk);
      expq.delete();
      add_load(e_base, 336);
      check_seq($sformatf("rnd%0d", it));
    end

    // small instance: no font, four program bytes
    s_reset_n = 1'b1;
    @(negedge clk);
    e_base = edge_n;
    for (int n = 0; n < 50 && !s_done; n++) @(negedge clk);
    check("small_done_edge", 64'(edge_n), 64'(e_base + 4));
    check("small_hold", 64'(s_cpu_hold), 64'd0);
    repeat (3) @(negedge clk);
    check("small_count", 64'(cap_s.size()), 64'd4);
    for (int i = 0; i < 4 && i < cap_s.size(); i++)
      check($sformatf("small_wr%0d", i), 64'(cap_s[i]),
            64'(wr_t'({32'(e_base + 32'(i)), 12'h200 + 12'(i), sd[i]})));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/chip8_mem_loader.md
Name: chip8_mem_loader

Overview:
- Boot-time loader that fills CHIP-8 main RAM before the CPU runs. It writes the built-in 80-byte hex font to RAM at FONT_BASE, then copies PROG_LEN program bytes out of the asynchronous program ROM into RAM at PROG_START.
- Sits directly downstream of the program ROM and upstream of the RAM write port. It holds the CPU in reset until the copy is complete.

Parameters:
- PROG_START, 12'h200: first program address, used for both ROM reads and RAM writes.
- PROG_LEN, 256: number of program bytes copied (1..3584).
- FONT_BASE, 12'h000: RAM address of font byte 0.
- LOAD_FONT, 1: when 0, skip the font phase entirely.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; reloads RAM when the block is in DONE.
- rom_address  out  12  read address to the program ROM.
- rom_data  in  8  ROM output; combinational from rom_address, valid in the same cycle.
- ram_address  out  12  RAM write address (registered).
- ram_data  out  8  RAM write data (registered).
- ram_we  out  1  RAM write strobe (registered); exactly one byte written per high cycle.
- done  out  1  high when RAM is fully loaded.
- cpu_hold  out  1  holds the CPU in reset; always equal to ~done.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State goes to FONT (or PROG if LOAD_FONT=0); count=0.
  - ram_we=0, ram_address=0, ram_data=0, done=0, cpu_hold=1.
  - rom_address=PROG_START.
- Reset asserted mid-load aborts immediately: no further ram_we pulses, and the load restarts from count 0 after release.
- State FONT:
  - Each cycle, register ram_address=FONT_BASE+count, ram_data=font[count], ram_we=1. count increments.
  - Font table is the standard CHIP-8 set, glyphs 0..F, 5 bytes each. Glyph 0 = F0 90 90 90 F0; glyph 1 = 20 60 20 20 70; glyph F = F0 80 F0 80 80.
  - At count=79: write the last font byte, clear count, go to PROG.
- State PROG:
  - rom_address=PROG_START+count (combinational from count).
  - Each cycle, register ram_address=rom_address, ram_data=rom_data, ram_we=1. count increments.
  - At count=PROG_LEN-1: write the last byte, go to FIN.
- State FIN: ram_we=0; set done=1 and go to DONE. done rises exactly one cycle after the final ram_we pulse.
- State DONE:
  - ram_we=0; ram_address and ram_data hold their last values; done=1.
  - start=1 → done=0, count=0, go to FONT (or PROG if LOAD_FONT=0). The first new ram_we occurs one cycle after start is sampled.
- start while not in DONE is ignored (no restart, no stretch).
- Latency: a byte indexed at cycle k appears on the RAM port at cycle k+1. ram_we is continuous with no gaps from the first write through the last, with no pause between phases.
- Timing after reset release with defaults: writes occur in cycles 1..336 (80 font + 256 program); done=1 from cycle 337.
- Arithmetic: all addresses are 12-bit and wrap modulo 4096. count is wide enough for PROG_LEN (12 bits). PROG_START+PROG_LEN>4096 is unsupported.
- Simultaneous reset_n=0 and start=1: reset wins.

Test Plan:
- Defaults, bench ROM returns (addr[7:0] ^ 8'h5A); release reset → 336 contiguous writes. RAM[0x000]=F0, RAM[0x005]=20, RAM[0x04F]=80, RAM[0x200]=5A, RAM[0x2FF]=A5. done rises in cycle 337; cpu_hold falls in the same cycle.
- Monitor RAM port during load → every ram_address in 0x000..0x04F and 0x200..0x2FF written exactly once, in ascending order. No writes anywhere else; ram_we low after cycle 336.
- Pulse start at cycle 100 (mid-load) → ignored: write sequence unchanged, done still at cycle 337.
- Pulse start once in DONE → done=0 next cycle; the full 336-write sequence repeats, then done=1 again.
- Assert reset_n=0 at cycle 150 for 2 cycles → ram_we=0 and done=0 during reset. After release, writes restart at address 0x000 with data F0.
- LOAD_FONT=0, PROG_LEN=4 → exactly 4 writes to 0x200..0x203 in cycles 1..4, data 5A,5B,58,59; done=1 at cycle 5.
